// File: rtl/wr_arria10_rx_det_align.sv
// ---------------------------------------------------------------------------
// wr_arria10_rx_det_align
//
// Deterministic-latency RX alignment controller for the Arria10 deterministic
// PHY. It runs in the recovered RX clock domain. The controller drives the
// RX PCS digital reset and the word-aligner pattern-align request, then reads
// back the reported bitslip boundary. If that boundary is not in the accepted
// set, it resets the PCS again. The accepted boundary gives a fixed RX
// latency that can be calibrated.
//
// Ports:
//   clk_rx_i                 recovered RX parallel clock
//   rst_n_i                  asynchronous active-low reset
//   enable_i                 level enable; low forces IDLE
//   rx_is_lockedtodata_i     CDR lock (asynchronous, synchronised here)
//   rx_syncstatus_i          word aligner sync status
//   rx_bitslipboundarysel_i  PHY-reported bitslip boundary
//   rx_disperr_i             disparity error (error-counter build only)
//   rx_errdetect_i           8b/10b code error (error-counter build only)
//   rx_digitalreset_o        RX PCS digital reset request
//   rx_wa_patternalign_o     single-cycle pattern-align pulse
//   rdy_o                    aligned on an accepted boundary
//   bitslip_o                boundary latched in CHECK
//   retry_cnt_o              retries in the current acquisition
//   fail_o                   sticky; retry budget exhausted
//   err_cnt_o                errors in the current window (error-counter build)
//
// Optional feature macro: WR_A10_DET_ALIGN_ERRCNT_EN
//   Defined: counts disparity/code errors in LOCKED over 1024-cycle windows.
//   Reaching 16 errors in a window forces a realign.
// ---------------------------------------------------------------------------
module wr_arria10_rx_det_align #(
    parameter int unsigned g_rst_cycles    = 32,
    parameter int unsigned g_align_timeout = 1023,
    parameter int unsigned g_sync_cycles   = 4,
    parameter logic [31:0] g_target_mask   = 32'h55555555,
    parameter int unsigned g_max_retries   = 255,
    parameter int unsigned g_loss_cycles   = 4
) (
    input  logic       clk_rx_i,
    input  logic       rst_n_i,
    input  logic       enable_i,
    input  logic       rx_is_lockedtodata_i,
    input  logic       rx_syncstatus_i,
    input  logic [4:0] rx_bitslipboundarysel_i,
    input  logic       rx_disperr_i,
    input  logic       rx_errdetect_i,
    output logic       rx_digitalreset_o,
    output logic       rx_wa_patternalign_o,
    output logic       rdy_o,
    output logic [4:0] bitslip_o,
    output logic [7:0] retry_cnt_o,
    output logic       fail_o
`ifdef WR_A10_DET_ALIGN_ERRCNT_EN
    ,
    output logic [7:0] err_cnt_o
`endif
);

    localparam int unsigned RstW  = $clog2(g_rst_cycles + 1);
    localparam int unsigned TmoW  = $clog2(g_align_timeout + 1);
    localparam int unsigned SyncW = $clog2(g_sync_cycles + 1);
    localparam int unsigned LossW = $clog2(g_loss_cycles + 1);

    localparam logic [RstW-1:0]  RstLoad  = RstW'(g_rst_cycles - 1);
    localparam logic [TmoW-1:0]  TmoLast  = TmoW'(g_align_timeout - 1);
    localparam logic [SyncW-1:0] SyncLast = SyncW'(g_sync_cycles - 1);
    localparam logic [LossW-1:0] LossLast = LossW'(g_loss_cycles - 1);
    localparam logic [7:0]       RetryMax = 8'(g_max_retries);

    typedef enum logic [2:0] {
        StIdle,
        StReset,
        StAlign,
        StCheck,
        StLocked,
        StFail
    } state_e;

    state_e r_state, w_state_d;

    logic             r_lock_meta, r_lock_s;
    logic [RstW-1:0]  r_rst_cnt, w_rst_cnt_d;
    logic [TmoW-1:0]  r_tmo_cnt, w_tmo_cnt_d;
    logic [SyncW-1:0] r_sync_cnt, w_sync_cnt_d;
    logic [LossW-1:0] r_loss_cnt, w_loss_cnt_d;
    logic [7:0]       r_retry_cnt, w_retry_cnt_d;
    logic             r_fail, w_fail_d;
    logic [4:0]       r_bitslip, w_bitslip_d;
    logic             r_digrst, w_digrst_d;
    logic             r_patalign, w_patalign_d;
    logic             r_rdy, w_rdy_d;

    logic w_go_reset;
    logic w_retry;
    logic w_err_hit;

    // CDR lock is asynchronous to the recovered clock.
    always_ff @(posedge clk_rx_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_lock_meta <= 1'b0;
            r_lock_s    <= 1'b0;
        end else begin
            r_lock_meta <= rx_is_lockedtodata_i;
            r_lock_s    <= r_lock_meta;
        end
    end

`ifdef WR_A10_DET_ALIGN_ERRCNT_EN
    logic [7:0] r_err_cnt, w_err_cnt_d;
    logic [9:0] r_win_cnt, w_win_cnt_d;
    logic [7:0] w_err_sum;

    always_comb begin
        w_err_sum   = r_err_cnt + {7'd0, rx_disperr_i | rx_errdetect_i};
        w_err_cnt_d = 8'd0;
        w_win_cnt_d = 10'd0;
        w_err_hit   = 1'b0;
        // The window starts from zero on LOCKED entry because the counters
        // are held clear in every other state.
        if (r_state == StLocked) begin
            w_win_cnt_d = r_win_cnt + 10'd1;
            if (r_win_cnt != 10'd1023) begin
                w_err_cnt_d = w_err_sum;
                w_err_hit   = (w_err_sum == 8'd16);
            end
        end
    end

    always_ff @(posedge clk_rx_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_err_cnt <= 8'd0;
            r_win_cnt <= 10'd0;
        end else begin
            r_err_cnt <= w_err_cnt_d;
            r_win_cnt <= w_win_cnt_d;
        end
    end

    assign err_cnt_o = r_err_cnt;
`else
    logic w_unused_err;
    assign w_unused_err = rx_disperr_i ^ rx_errdetect_i;
    assign w_err_hit    = 1'b0;
`endif

    // Next-state logic. Priority: enable low, then lock low, then
    // timeout/loss, then success.
    always_comb begin
        w_state_d     = r_state;
        w_rst_cnt_d   = r_rst_cnt;
        w_tmo_cnt_d   = r_tmo_cnt;
        w_sync_cnt_d  = r_sync_cnt;
        w_loss_cnt_d  = r_loss_cnt;
        w_retry_cnt_d = r_retry_cnt;
        w_fail_d      = r_fail;
        w_bitslip_d   = r_bitslip;
        w_go_reset    = 1'b0;
        w_retry       = 1'b0;

        if (!enable_i) begin
            w_state_d     = StIdle;
            w_retry_cnt_d = 8'd0;
            w_fail_d      = 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (r_lock_s) begin
                        w_go_reset = 1'b1;
                    end
                end
                StReset: begin
                    // Hold the PCS in reset while the CDR is unlocked.
                    if (!r_lock_s) begin
                        w_go_reset = 1'b1;
                    end else if (r_rst_cnt == '0) begin
                        w_state_d    = StAlign;
                        w_tmo_cnt_d  = '0;
                        w_sync_cnt_d = '0;
                    end else begin
                        w_rst_cnt_d = r_rst_cnt - 1'b1;
                    end
                end
                StAlign: begin
                    if (!r_lock_s) begin
                        w_go_reset = 1'b1;
                    end else if (r_tmo_cnt == TmoLast) begin
                        w_retry = 1'b1;
                    end else if (rx_syncstatus_i && (r_sync_cnt == SyncLast)) begin
                        w_state_d = StCheck;
                    end else begin
                        w_tmo_cnt_d  = r_tmo_cnt + 1'b1;
                        w_sync_cnt_d = rx_syncstatus_i ? r_sync_cnt + 1'b1 : '0;
                    end
                end
                StCheck: begin
                    if (!r_lock_s) begin
                        w_go_reset = 1'b1;
                    end else begin
                        w_bitslip_d = rx_bitslipboundarysel_i;
                        if (g_target_mask[rx_bitslipboundarysel_i]) begin
                            w_state_d     = StLocked;
                            w_retry_cnt_d = 8'd0;
                            w_loss_cnt_d  = '0;
                        end else begin
                            w_retry = 1'b1;
                        end
                    end
                end
                StLocked: begin
                    // Loss and error realigns do not consume retries.
                    if (!r_lock_s) begin
                        w_go_reset = 1'b1;
                    end else if (!rx_syncstatus_i && (r_loss_cnt == LossLast)) begin
                        w_go_reset = 1'b1;
                    end else if (w_err_hit) begin
                        w_go_reset = 1'b1;
                    end else begin
                        w_loss_cnt_d = rx_syncstatus_i ? '0 : r_loss_cnt + 1'b1;
                    end
                end
                StFail: begin
                    // Only enable low releases FAIL.
                end
                default: begin
                    w_state_d = StIdle;
                end
            endcase

            if (w_retry) begin
                if (r_retry_cnt == RetryMax) begin
                    w_state_d = StFail;
                    w_fail_d  = 1'b1;
                end else begin
                    w_retry_cnt_d = r_retry_cnt + 8'd1;
                    w_go_reset    = 1'b1;
                end
            end

            if (w_go_reset) begin
                w_state_d   = StReset;
                w_rst_cnt_d = RstLoad;
            end
        end
    end

    // Outputs are registered versions of what the next state implies.
    always_comb begin
        w_digrst_d   = !((w_state_d == StAlign) || (w_state_d == StCheck) ||
                         (w_state_d == StLocked));
        w_patalign_d = (r_state == StReset) && (w_state_d == StAlign);
        w_rdy_d      = (w_state_d == StLocked);
    end

    always_ff @(posedge clk_rx_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state     <= StIdle;
            r_rst_cnt   <= '0;
            r_tmo_cnt   <= '0;
            r_sync_cnt  <= '0;
            r_loss_cnt  <= '0;
            r_retry_cnt <= 8'd0;
            r_fail      <= 1'b0;
            r_bitslip   <= 5'd0;
            r_digrst    <= 1'b1;
            r_patalign  <= 1'b0;
            r_rdy       <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_rst_cnt   <= w_rst_cnt_d;
            r_tmo_cnt   <= w_tmo_cnt_d;
            r_sync_cnt  <= w_sync_cnt_d;
            r_loss_cnt  <= w_loss_cnt_d;
            r_retry_cnt <= w_retry_cnt_d;
            r_fail      <= w_fail_d;
            r_bitslip   <= w_bitslip_d;
            r_digrst    <= w_digrst_d;
            r_patalign  <= w_patalign_d;
            r_rdy       <= w_rdy_d;
        end
    end

    assign rx_digitalreset_o    = r_digrst;
    assign rx_wa_patternalign_o = r_patalign;
    assign rdy_o                = r_rdy;
    assign bitslip_o            = r_bitslip;
    assign retry_cnt_o          = r_retry_cnt;
    assign fail_o               = r_fail;

endmodule
